// File: rtl/encoder_8_to_3_seq.sv
// Sequential 8-to-3 encoder: latches falling edges on active-low request lines
// and presents them as 3-bit codes in priority order over valid/ready.

module encoder_8_to_3_seq_lane (
  input  logic clk,
  input  logic rst,
  input  logic armed,
  input  logic enable,
  input  logic req_n,
  input  logic ack,
  output logic pend,
  output logic pend_nxt,
  output logic lost
);
  logic req_d;
  logic fall;

  // req_d tracks the line even while gated so re-enabling never fakes an edge
  assign fall     = armed & ~enable & req_d & ~req_n;
  assign pend_nxt = (pend & ~ack) | fall;
  assign lost     = fall & pend & ~ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d <= 1'b1;
      pend  <= 1'b0;
    end else begin
      req_d <= req_n;
      pend  <= pend_nxt;
    end
  end
endmodule

module encoder_8_to_3_seq #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] in,
  output logic [2:0] out,
  output logic       valid,
  input  logic       ready,
  output logic       multi,
  output logic       overrun
);
  localparam int NUM_LANES = 8;

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t                 state, state_nxt;
  logic [2:0]             out_nxt;
  logic                   armed;
  logic                   hs;
  logic [NUM_LANES-1:0]   ack_mask, pending, pending_nxt, lost;

  function automatic logic [2:0] encode(input logic [NUM_LANES-1:0] v);
    encode = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (HIGH_FIRST) begin
        if (v[i]) encode = 3'(i);
      end else begin
        if (v[NUM_LANES-1-i]) encode = 3'(NUM_LANES-1-i);
      end
    end
  endfunction

  assign valid    = (state == PRESENT);
  assign hs       = valid & ready;
  assign ack_mask = hs ? (8'(1) << out) : '0;
  assign multi    = (pending & (pending - 8'd1)) != '0;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    encoder_8_to_3_seq_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .armed    (armed),
      .enable   (enable),
      .req_n    (in[g]),
      .ack      (ack_mask[g]),
      .pend     (pending[g]),
      .pend_nxt (pending_nxt[g]),
      .lost     (lost[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed   <= 1'b0;
      overrun <= 1'b0;
      state   <= IDLE;
      out     <= '0;
    end else begin
      armed   <= 1'b1;
      overrun <= overrun | (|lost);
      state   <= state_nxt;
      out     <= out_nxt;
    end
  end

  // A presented code is held until accepted, even if higher priority arrives
  always_comb begin
    state_nxt = state;
    out_nxt   = out;
    case (state)
      IDLE: if (pending != '0) begin
        state_nxt = PRESENT;
        out_nxt   = encode(pending);
      end
      PRESENT: if (hs) begin
        if (pending_nxt != '0) out_nxt = encode(pending_nxt);
        else                   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_encoder_8_to_3_seq.sv
// Directed bench for encoder_8_to_3_seq; a HIGH_FIRST=0 twin shares all inputs.

module tb_encoder_8_to_3_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] in = 8'hFF;
  logic       ready = 1'b0;
  logic [2:0] out_hi, out_lo;
  logic       valid_hi, valid_lo, multi_hi, multi_lo, ovr_hi, ovr_lo;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  encoder_8_to_3_seq #(.HIGH_FIRST(1'b1)) dut_hi (
    .clk(clk), .rst(rst), .enable(enable), .in(in), .out(out_hi),
    .valid(valid_hi), .ready(ready), .multi(multi_hi), .overrun(ovr_hi)
  );

  encoder_8_to_3_seq #(.HIGH_FIRST(1'b0)) dut_lo (
    .clk(clk), .rst(rst), .enable(enable), .in(in), .out(out_lo),
    .valid(valid_lo), .ready(ready), .multi(multi_lo), .overrun(ovr_lo)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] dec3to8(input logic [2:0] c);
    dec3to8 = ~(8'(1) << c);
  endfunction

  initial begin
    // async reset before any clock edge, lines toggling
    in = 8'h00;
    #2 rst = 1'b1;
    #1;
    chk("rst_out", 8'(out_hi), 8'h0);
    chk("rst_valid", 8'(valid_hi), 8'h0);
    chk("rst_multi", 8'(multi_hi), 8'h0);
    chk("rst_ovr", 8'(ovr_hi), 8'h0);
    for (int i = 0; i < 6; i++) begin
      in = (i % 2) ? 8'hFF : 8'h00;
      #4;
    end
    in = 8'h00;
    step();
    chk("rst_hold_valid", 8'(valid_hi), 8'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("held_low_no_req", 8'({valid_hi, valid_lo}), 8'h0);
    end
    in = 8'hFF;
    step();

    // single request on bit 2
    in = 8'hFB;
    step();
    in = 8'hFF;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("single_valid", 8'(valid_hi), 8'h1);
      chk("single_out", 8'(out_hi), 8'h2);
      step();
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("single_drain", 8'(valid_hi), 8'h0);

    // two requests, priority order
    ready = 1'b1;
    in = 8'h6F;
    step();
    in = 8'hFF;
    step();
    chk("multi1_out_hi", 8'(out_hi), 8'h7);
    chk("multi1_out_lo", 8'(out_lo), 8'h4);
    chk("multi1_flag", 8'(multi_hi), 8'h1);
    step();
    chk("multi2_out_hi", 8'(out_hi), 8'h4);
    chk("multi2_out_lo", 8'(out_lo), 8'h7);
    chk("multi2_flag", 8'(multi_hi), 8'h0);
    chk("multi2_valid", 8'(valid_hi), 8'h1);
    step();
    chk("multi_drain", 8'({valid_hi, valid_lo}), 8'h0);
    ready = 1'b0;

    // presented code holds while a higher priority arrives
    in = 8'hFB;
    step();
    in = 8'hFF;
    step();
    in = 8'hBF;
    step();
    in = 8'hFF;
    chk("stable_out", 8'(out_hi), 8'h2);
    chk("stable_multi", 8'(multi_hi), 8'h1);
    ready = 1'b1;
    step();
    chk("stable_next", 8'(out_hi), 8'h6);
    chk("stable_next_valid", 8'(valid_hi), 8'h1);
    step();
    ready = 1'b0;
    chk("stable_drain", 8'(valid_hi), 8'h0);

    // overrun: second fall of bit 3 before acceptance
    in = 8'hF7;
    step();
    in = 8'hFF;
    step();
    chk("ovr_pre", 8'(ovr_hi), 8'h0);
    in = 8'hF7;
    step();
    in = 8'hFF;
    chk("ovr_set", 8'(ovr_hi), 8'h1);
    ready = 1'b1;
    step();
    step();
    ready = 1'b0;
    chk("ovr_sticky", 8'(ovr_hi), 8'h1);
    chk("ovr_drain", 8'(valid_hi), 8'h0);
    rst = 1'b1;
    #1;
    chk("ovr_cleared", 8'(ovr_hi), 8'h0);
    rst = 1'b0;
    step();

    // refall in the same cycle as its handshake: set wins, no overrun
    in = 8'hF7;
    step();
    in = 8'hFF;
    step();
    chk("same_pre_out", 8'(out_hi), 8'h3);
    in = 8'hF7;
    ready = 1'b1;
    step();
    in = 8'hFF;
    chk("same_ovr", 8'(ovr_hi), 8'h0);
    chk("same_valid", 8'(valid_hi), 8'h1);
    chk("same_out", 8'(out_hi), 8'h3);
    step();
    ready = 1'b0;
    chk("same_drain", 8'(valid_hi), 8'h0);

    // gated capture, line still low when gate reopens
    enable = 1'b1;
    in = 8'hDF;
    step();
    step();
    enable = 1'b0;
    step();
    step();
    chk("gated_valid", 8'(valid_hi), 8'h0);
    chk("gated_multi", 8'(multi_hi), 8'h0);
    in = 8'hFF;
    step();

    // round trip through a 3-to-8 decoder
    for (int c = 0; c < 8; c++) begin
      in = dec3to8(3'(c));
      step();
      in = 8'hFF;
      step();
      chk("rt_valid", 8'(valid_hi), 8'h1);
      chk("rt_out", 8'(out_hi), 8'(c));
      ready = 1'b1;
      step();
      ready = 1'b0;
    end
    chk("rt_drain", 8'(valid_hi), 8'h0);

    // reset mid-present drops valid without a clock
    in = 8'hFB;
    step();
    in = 8'hFF;
    step();
    chk("rstmid_pre", 8'(valid_hi), 8'h1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_valid", 8'(valid_hi), 8'h0);
    chk("rstmid_out", 8'(out_hi), 8'h0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("rstmid_discard", 8'(valid_hi), 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1, "timeout");
  end
endmodule
